seq_mult_16b: RTL and testbench

- Sequential unsigned 16x16 shift-and-add multiplier for the KGP-RISC ALU datapath.
- Sits directly upstream of the 16-bit ripple-carry adder and drives its A, B and Cin every cycle.
- One adder_16B instance forms each partial sum; this block consumes the sum and carry-out and accumulates the 32-bit product.
- Fixed latency, start/done handshake, result held stable until the next operation.

---
 rtl/seq_mult_16b.sv | 135 +++++++++++++
 tb/tb_seq_mult_16b.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_16b.sv
// Sequential unsigned 16x16 shift-and-add multiplier with start/done handshake.
// A ripple-carry adder_16B forms each partial sum; its carry-out feeds the shift.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module adder_16B #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0] c;

  assign c[0] = cin;

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_bit
      full_adder u_fa (
        .a   (a[i]),
        .b   (b[i]),
        .cin (c[i]),
        .sum (sum[i]),
        .cout(c[i+1])
      );
    end
  endgenerate

  assign cout = c[N];
endmodule

module seq_mult_16b #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  mcand, hi, lo;
  logic [CW-1:0] count;
  logic [N-1:0]  add_b, sum;
  logic          cout;
  logic          load, step, last;
  logic [2*N-1:0] shifted;

  // Partial product is gated by the multiplier LSB; carry-in is never used.
  assign add_b = lo[0] ? mcand : '0;

  adder_16B #(.N(N)) u_add (
    .a   (hi),
    .b   (add_b),
    .cin (1'b0),
    .sum (sum),
    .cout(cout)
  );

  // 33-bit right shift of {cout,sum,lo}; keeping cout is what makes 0xFFFF^2 exact.
  assign shifted = {cout, sum, lo[N-1:1]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (count == LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      if (load) begin
        mcand <= A;
        hi    <= '0;
        lo    <= B;
        count <= '0;
      end else if (step) begin
        {hi, lo} <= shifted;
        count    <= count + 1'b1;
      end
      if (last) product <= shifted;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule

// File: tb/tb_seq_mult_16b.sv
// Scoreboard bench for seq_mult_16b: expected products queued at start, popped on done.

module tb_seq_mult_16b;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        busy, done;
  logic [31:0] product;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  seq_mult_16b dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (a),
    .B      (b),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one op and follow it to done; the caller does the comparisons.
  task automatic do_op(input logic [15:0] xa, input logic [15:0] xb,
                       output int lat, output int bcnt, output logic [31:0] got,
                       output bit moved);
    logic [31:0] held;
    held  = product;
    lat   = -1;
    bcnt  = 0;
    moved = 1'b0;
    got   = 'x;
    a = xa; b = xb; start = 1'b1;
    exp_q.push_back({16'h0, xa} * {16'h0, xb});
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin
        lat = i;
        got = product;
        break;
      end
      if (busy) bcnt++;
      if (product !== held) moved = 1'b1;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    n_checks++;
    if ({busy, done, product} !== 34'h0)
      $display("FAIL reset got busy=%b done=%b product=%h want 0/0/0", busy, done, product);
    else n_pass++;
  endtask

  task automatic test_basic(input logic [15:0] xa, input logic [15:0] xb, input string nm);
    int lat, bcnt; logic [31:0] got, want; bit moved;
    do_op(xa, xb, lat, bcnt, got, moved);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
    n_checks++;
    if (lat != 17) $display("FAIL %s_latency got %0d want 17", nm, lat);
    else n_pass++;
    n_checks++;
    if (bcnt != 16) $display("FAIL %s_busy_cycles got %0d want 16", nm, bcnt);
    else n_pass++;
    n_checks++;
    if (got !== want) $display("FAIL %s_product got %h want %h", nm, got, want);
    else n_pass++;
    n_checks++;
    if (moved) $display("FAIL %s_product_hold got changed want stable", nm);
    else n_pass++;
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s_done_pulse got done=%b busy=%b want 0/0", nm, done, busy);
    else n_pass++;
  endtask

  task automatic test_ignore_start();
    logic [31:0] want;
    bit seen = 1'b0;
    a = 16'd7; b = 16'd9; start = 1'b1;
    exp_q.push_back(32'h0000_003F);
    tick();
    start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 5) begin a = 16'd2; b = 16'd2; start = 1'b1; end
      if (i == 6) start = 1'b0;
      if (i == 10) begin a = 16'hAAAA; b = 16'h5555; end
      if (done) begin
        seen = 1'b1;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        n_checks++;
        if (product !== want) $display("FAIL ignore_start got %h want %h", product, want);
        else n_pass++;
        break;
      end
      tick();
    end
    n_checks++;
    if (!seen) $display("FAIL ignore_start_done got none want pulse");
    else n_pass++;
    tick();
    test_basic(16'h8000, 16'd2, "msb_times_two");
  endtask

  task automatic test_abort();
    bit stray = 1'b0;
    a = 16'h00FF; b = 16'h0101; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 8; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({busy, done, product} !== 34'h0)
      $display("FAIL abort_reset got busy=%b done=%b product=%h want 0/0/0", busy, done, product);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) stray = 1'b1;
      tick();
    end
    n_checks++;
    if (stray) $display("FAIL abort_no_done got activity want idle");
    else n_pass++;
    test_basic(16'h00FF, 16'h0101, "after_abort");
  endtask

  task automatic test_back_to_back();
    logic [31:0] held, want;
    int last_t = -1, ndone = 0;
    bit moved = 1'b0;
    held = product;
    for (int k = 0; k < 3; k++) exp_q.push_back(32'h0001_0000);
    a = 16'h0100; b = 16'h0100; start = 1'b1;
    for (int t = 0; t < 80 && ndone < 3; t++) begin
      tick();
      if (done) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        n_checks++;
        if (product !== want) $display("FAIL b2b_product%0d got %h want %h", ndone, product, want);
        else n_pass++;
        if (last_t >= 0) begin
          n_checks++;
          if (t - last_t != 18) $display("FAIL b2b_spacing%0d got %0d want 18", ndone, t - last_t);
          else n_pass++;
        end
        last_t = t;
        held = product;
        ndone++;
      end else if (product !== held) moved = 1'b1;
    end
    start = 1'b0;
    n_checks++;
    if (ndone != 3) $display("FAIL b2b_count got %0d want 3", ndone);
    else n_pass++;
    n_checks++;
    if (moved) $display("FAIL b2b_hold got changed want stable");
    else n_pass++;
    tick(); tick();
    n_checks++;
    if (busy !== 1'b0 || exp_q.size() != 0)
      $display("FAIL b2b_drain got busy=%b queued=%0d want 0/0", busy, exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic(16'd3, 16'd5, "three_by_five");
    test_basic(16'hFFFF, 16'hFFFF, "max_by_max");
    test_basic(16'h1234, 16'h0000, "zero_b");
    test_basic(16'h0000, 16'hBEEF, "zero_a");
    test_basic(16'hABCD, 16'h1357, "mixed");
    test_ignore_start();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
